// File: rtl/m31_pkg.sv
`default_nettype none
// ============================================================================
// Module  : m31_pkg
// Brief   : Mersenne-31 field types, modular arithmetic, Poseidon2 M4 MDS and
//           internal-layer diagonal tables shared by the round pipeline.
// Revision: 1.0
// ============================================================================
package m31_pkg;

    typedef logic [30:0]      m31_t;
    typedef logic [3:0][30:0] m31x4_t;

    typedef enum logic {
        FULL    = 1'b0,
        PARTIAL = 1'b1
    } round_mode_t;

    localparam m31_t P_M31    = 31'h7FFF_FFFF;
    localparam int   SBOX_LAT = 12;

    // Internal diagonal: lane 0 is -2, lane i>0 is 2^(i-1).
    localparam m31_t M31_DIAG_8 [8] = '{
        31'd2147483645, 31'd1, 31'd2, 31'd4, 31'd8, 31'd16, 31'd32, 31'd64
    };
    localparam m31_t M31_DIAG_12 [12] = '{
        31'd2147483645, 31'd1, 31'd2, 31'd4, 31'd8, 31'd16, 31'd32, 31'd64,
        31'd128, 31'd256, 31'd512, 31'd1024
    };
    localparam m31_t M31_DIAG_16 [16] = '{
        31'd2147483645, 31'd1, 31'd2, 31'd4, 31'd8, 31'd16, 31'd32, 31'd64,
        31'd128, 31'd256, 31'd512, 31'd1024, 31'd2048, 31'd4096, 31'd8192,
        31'd16384
    };
    localparam m31_t M31_DIAG_20 [20] = '{
        31'd2147483645, 31'd1, 31'd2, 31'd4, 31'd8, 31'd16, 31'd32, 31'd64,
        31'd128, 31'd256, 31'd512, 31'd1024, 31'd2048, 31'd4096, 31'd8192,
        31'd16384, 31'd32768, 31'd65536, 31'd131072, 31'd262144
    };
    localparam m31_t M31_DIAG_24 [24] = '{
        31'd2147483645, 31'd1, 31'd2, 31'd4, 31'd8, 31'd16, 31'd32, 31'd64,
        31'd128, 31'd256, 31'd512, 31'd1024, 31'd2048, 31'd4096, 31'd8192,
        31'd16384, 31'd32768, 31'd65536, 31'd131072, 31'd262144, 31'd524288,
        31'd1048576, 31'd2097152, 31'd4194304
    };

    function automatic m31_t m31_canon(input m31_t x);
        return (x == P_M31) ? '0 : x;
    endfunction

    function automatic m31_t m31_add(input m31_t a, input m31_t b);
        logic [31:0] s;
        s = {1'b0, a} + {1'b0, b};
        if (s >= {1'b0, P_M31}) begin
            s = s - {1'b0, P_M31};
        end
        return s[30:0];
    endfunction

    // 2^31 == 1 mod p, so the high half folds straight onto the low half.
    function automatic m31_t m31_mul(input m31_t a, input m31_t b);
        logic [61:0] prod;
        logic [31:0] t;
        m31_t        r;
        prod = 62'(a) * 62'(b);
        t    = {1'b0, prod[30:0]} + {1'b0, prod[61:31]};
        r    = t[30:0] + {30'b0, t[31]};
        return (r == P_M31) ? '0 : r;
    endfunction

    // Circulant(2,3,1,1) evaluated with shared partial sums.
    function automatic m31x4_t m4_mds(input m31x4_t x);
        m31x4_t y;
        m31_t   t01, t23, t0123, t01123, t01233;
        t01    = m31_add(x[0], x[1]);
        t23    = m31_add(x[2], x[3]);
        t0123  = m31_add(t01, t23);
        t01123 = m31_add(t0123, x[1]);
        t01233 = m31_add(t0123, x[3]);
        y[0]   = m31_add(t01123, t01);
        y[1]   = m31_add(t01123, m31_add(x[2], x[2]));
        y[2]   = m31_add(t01233, t23);
        y[3]   = m31_add(t01233, m31_add(x[0], x[0]));
        return y;
    endfunction

    function automatic m31_t m31_diag(input int width, input int idx);
        case (width)
            8:       return M31_DIAG_8[idx[2:0]];
            12:      return M31_DIAG_12[idx[3:0]];
            16:      return M31_DIAG_16[idx[3:0]];
            20:      return M31_DIAG_20[idx[4:0]];
            default: return M31_DIAG_24[idx[4:0]];
        endcase
    endfunction

endpackage
`default_nettype wire

// File: rtl/m31_sbox5.sv
`default_nettype none
// ============================================================================
// Module  : m31_sbox5
// Brief   : Pipelined x^5 over M31, SBOX_LAT stages, global stall enable.
//           A bypass lane reuses the operand carry registers as a delay line.
// Revision: 1.0
// ============================================================================
module m31_sbox5
    import m31_pkg::*;
(
    input  logic clk,
    input  logic i_en,
    input  logic i_bypass,
    input  m31_t i_x,
    output m31_t o_y
);

    m31_t r_x1;
    m31_t r_sq;
    m31_t r_x2;
    m31_t r_q4;
    logic r_byp1;
    logic r_byp2;
    m31_t r_tail [SBOX_LAT-2];

    always_ff @(posedge clk) begin
        if (i_en) begin
            r_x1      <= i_x;
            r_sq      <= m31_mul(i_x, i_x);
            r_byp1    <= i_bypass;
            r_x2      <= r_x1;
            r_q4      <= m31_mul(r_sq, r_sq);
            r_byp2    <= r_byp1;
            r_tail[0] <= r_byp2 ? r_x2 : m31_mul(r_q4, r_x2);
            for (int i = 1; i < SBOX_LAT - 2; i++) begin
                r_tail[i] <= r_tail[i-1];
            end
        end
    end

    assign o_y = r_tail[SBOX_LAT-3];

endmodule
`default_nettype wire

// File: rtl/m31_p2_round_pipe.sv
`default_nettype none
// ============================================================================
// Module  : m31_p2_round_pipe
// Brief   : Poseidon2 full/partial round over M31, valid/ready with stall.
//           Optional macro M31_ROUND_CHECK_EN enables the sticky err_o flag.
// Revision: 1.0
// ============================================================================
module m31_p2_round_pipe
    import m31_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int TAG_W = 8
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                in_valid_i,
    output logic                in_ready_o,
    input  logic                mode_i,
    input  logic [TAG_W-1:0]    tag_i,
    input  logic [WIDTH*31-1:0] state_i,
    input  logic [WIDTH*31-1:0] const_i,
    output logic                out_valid_o,
    input  logic                out_ready_i,
    output logic [TAG_W-1:0]    tag_o,
    output logic [WIDTH*31-1:0] state_o,
    output logic                err_o
);

    localparam int c_NUM_BLK = WIDTH / 4;

    logic                w_en;
    round_mode_t         w_mode_in;
    logic [WIDTH-1:0]    w_byp;
    m31_t                w_sbox_in  [WIDTH];
    m31_t                w_sbox_out [WIDTH];
    logic [SBOX_LAT-1:0] r_vld;
    round_mode_t         r_mode [SBOX_LAT];
    logic [TAG_W-1:0]    r_tag  [SBOX_LAT];
    m31_t                w_m    [WIDTH];
    m31_t                w_col  [4];
    m31_t                w_sum;
    m31x4_t              w_blk;
    logic [WIDTH*31-1:0] w_lin;
    logic                r_out_vld;
    logic [TAG_W-1:0]    r_tag_out;
    logic [WIDTH*31-1:0] r_state;

    // One enable freezes every stage while the output is held.
    assign w_en       = !(r_out_vld && !out_ready_i);
    assign in_ready_o = w_en;

    always_comb begin
        w_mode_in = round_mode_t'(mode_i);
        w_byp     = '0;
        for (int i = 0; i < WIDTH; i++) begin
            w_byp[i]     = (w_mode_in == PARTIAL) && (i != 0);
            w_sbox_in[i] = w_byp[i] ? m31_canon(state_i[i*31 +: 31])
                                    : m31_add(m31_canon(state_i[i*31 +: 31]),
                                              m31_canon(const_i[i*31 +: 31]));
        end
    end

    for (genvar gi = 0; gi < WIDTH; gi++) begin : g_lane
        m31_sbox5 u_sbox (
            .clk      (clk),
            .i_en     (w_en),
            .i_bypass (w_byp[gi]),
            .i_x      (w_sbox_in[gi]),
            .o_y      (w_sbox_out[gi])
        );
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_vld <= '0;
        end else if (w_en) begin
            r_vld <= {r_vld[SBOX_LAT-2:0], in_valid_i};
        end
    end

    always_ff @(posedge clk) begin
        if (w_en) begin
            r_mode[0] <= w_mode_in;
            r_tag[0]  <= tag_i;
            for (int i = 1; i < SBOX_LAT; i++) begin
                r_mode[i] <= r_mode[i-1];
                r_tag[i]  <= r_tag[i-1];
            end
        end
    end

    // Both linear layers are built; the travelling mode picks one.
    always_comb begin
        w_sum = '0;
        w_blk = '0;
        w_lin = '0;
        for (int i = 0; i < WIDTH; i++) w_m[i] = '0;
        for (int j = 0; j < 4; j++) w_col[j] = '0;
        for (int b = 0; b < c_NUM_BLK; b++) begin
            for (int j = 0; j < 4; j++) w_blk[j] = w_sbox_out[4*b+j];
            w_blk = m4_mds(w_blk);
            for (int j = 0; j < 4; j++) w_m[4*b+j] = w_blk[j];
        end
        for (int i = 0; i < WIDTH; i++) begin
            w_col[i%4] = m31_add(w_col[i%4], w_m[i]);
            w_sum      = m31_add(w_sum, w_sbox_out[i]);
        end
        for (int i = 0; i < WIDTH; i++) begin
            if (r_mode[SBOX_LAT-1] == PARTIAL) begin
                w_lin[i*31 +: 31] = m31_add(w_sum,
                    m31_mul(m31_diag(WIDTH, i), w_sbox_out[i]));
            end else begin
                w_lin[i*31 +: 31] = m31_add(w_m[i], w_col[i%4]);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_out_vld <= 1'b0;
            r_tag_out <= '0;
            r_state   <= '0;
        end else if (w_en) begin
            r_out_vld <= r_vld[SBOX_LAT-1];
            if (r_vld[SBOX_LAT-1]) begin
                r_tag_out <= r_tag[SBOX_LAT-1];
                r_state   <= w_lin;
            end
        end
    end

    assign out_valid_o = r_out_vld;
    assign tag_o       = r_tag_out;
    assign state_o     = r_state;

`ifdef M31_ROUND_CHECK_EN
    logic w_noncanon;
    logic r_err;

    always_comb begin
        w_noncanon = 1'b0;
        for (int i = 0; i < WIDTH; i++) begin
            if ((state_i[i*31 +: 31] == P_M31) || (const_i[i*31 +: 31] == P_M31)) begin
                w_noncanon = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_err <= 1'b0;
        end else if (in_valid_i && w_en && w_noncanon) begin
            r_err <= 1'b1;
        end
    end

    assign err_o = r_err;
`else
    assign err_o = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_m31_p2_round_pipe.sv
`default_nettype none
// ============================================================================
// Module  : tb_m31_p2_round_pipe
// Brief   : Self-checking bench with an arithmetic reference model.
// Revision: 1.0
// ============================================================================
module tb_m31_p2_round_pipe;

    localparam int WIDTH = 16;
    localparam int TAG_W = 8;
    localparam int LW    = WIDTH * 31;
    localparam longint unsigned P = 64'd2147483647;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             in_valid = 1'b0;
    logic             mode = 1'b0;
    logic             out_ready = 1'b1;
    logic [TAG_W-1:0] tag_in = '0;
    logic [LW-1:0]    st_in = '0;
    logic [LW-1:0]    ct_in = '0;
    logic             in_ready;
    logic             out_valid;
    logic             err;
    logic [TAG_W-1:0] tag_out;
    logic [LW-1:0]    st_out;

    int checks   = 0;
    int failures = 0;
    int n_out    = 0;

    typedef struct {
        logic [TAG_W-1:0] tag;
        logic [LW-1:0]    st;
    } exp_t;
    exp_t q[$];

    logic             prev_stall = 1'b0;
    logic [LW-1:0]    prev_state = '0;
    logic [TAG_W-1:0] prev_tag = '0;

    m31_p2_round_pipe #(.WIDTH(WIDTH), .TAG_W(TAG_W)) dut (
        .clk         (clk),
        .rst         (rst),
        .in_valid_i  (in_valid),
        .in_ready_o  (in_ready),
        .mode_i      (mode),
        .tag_i       (tag_in),
        .state_i     (st_in),
        .const_i     (ct_in),
        .out_valid_o (out_valid),
        .out_ready_i (out_ready),
        .tag_o       (tag_out),
        .state_o     (st_out),
        .err_o       (err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [LW-1:0] got, input logic [LW-1:0] exp);
        checks++;
        assert (got === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", name, got, exp);
        end
    endtask

    function automatic longint unsigned pow5(input longint unsigned a);
        longint unsigned a2, a4;
        a2 = (a * a) % P;
        a4 = (a2 * a2) % P;
        return (a4 * a) % P;
    endfunction

    // Round computed directly from the field definition with a 4x4 matrix.
    function automatic logic [LW-1:0] model(input logic md, input logic [LW-1:0] s,
                                            input logic [LW-1:0] c);
        longint unsigned b [WIDTH];
        longint unsigned m [WIDTH];
        longint unsigned sv, cv, acc, d;
        int              mat [4][4];
        logic [LW-1:0]   y;
        mat = '{'{2, 3, 1, 1}, '{1, 2, 3, 1}, '{1, 1, 2, 3}, '{3, 1, 1, 2}};
        y = '0;
        for (int i = 0; i < WIDTH; i++) begin
            sv = 64'(s[i*31 +: 31]) % P;
            cv = 64'(c[i*31 +: 31]) % P;
            b[i] = (!md || i == 0) ? pow5((sv + cv) % P) : sv;
        end
        if (!md) begin
            for (int blk = 0; blk < WIDTH / 4; blk++) begin
                for (int r = 0; r < 4; r++) begin
                    acc = 0;
                    for (int j = 0; j < 4; j++) acc += 64'(mat[r][j]) * b[4*blk+j];
                    m[4*blk+r] = acc % P;
                end
            end
            for (int i = 0; i < WIDTH; i++) begin
                acc = m[i];
                for (int k = 0; k < WIDTH / 4; k++) acc += m[4*k + (i % 4)];
                y[i*31 +: 31] = 31'(acc % P);
            end
        end else begin
            acc = 0;
            for (int i = 0; i < WIDTH; i++) acc += b[i];
            acc = acc % P;
            for (int i = 0; i < WIDTH; i++) begin
                d = (i == 0) ? (P - 2) : (64'd1 << (i - 1));
                y[i*31 +: 31] = 31'((acc + d * b[i]) % P);
            end
        end
        return y;
    endfunction

    function automatic logic [LW-1:0] rand_vec();
        logic [LW-1:0] v;
        for (int i = 0; i < WIDTH; i++) v[i*31 +: 31] = 31'($urandom % 32'd2147483647);
        return v;
    endfunction

    // Scoreboard and hold checks, sampled on the falling edge.
    always @(negedge clk) begin
        exp_t e;
        if (rst) begin
            q.delete();
            prev_stall = 1'b0;
        end else begin
            if (prev_stall) begin
                chk("hold_valid", LW'(out_valid), LW'(1));
                chk("hold_state", st_out, prev_state);
                chk("hold_tag", LW'(tag_out), LW'(prev_tag));
            end
            if (out_valid && out_ready) begin
                if (q.size() == 0) begin
                    chk("spurious_out", LW'(out_valid), LW'(0));
                end else begin
                    e = q.pop_front();
                    chk("sb_tag", LW'(tag_out), LW'(e.tag));
                    chk("sb_state", st_out, e.st);
                    n_out++;
                end
            end
            if (in_valid && in_ready) q.push_back('{tag_in, model(mode, st_in, ct_in)});
            prev_stall = out_valid && !out_ready;
            prev_state = st_out;
            prev_tag   = tag_out;
        end
    end

    task automatic run_dir(input string nm, input logic md, input logic [TAG_W-1:0] tg,
                           input logic [LW-1:0] s, input logic [LW-1:0] c,
                           input logic [LW-1:0] exp);
        @(posedge clk); #1;
        in_valid = 1'b1; mode = md; tag_in = tg; st_in = s; ct_in = c;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (11) @(posedge clk);
        @(negedge clk);
        chk({nm, "_early"}, LW'(out_valid), LW'(0));
        @(negedge clk);
        chk({nm, "_valid"}, LW'(out_valid), LW'(1));
        chk(nm, st_out, exp);
        chk({nm, "_tag"}, LW'(tag_out), LW'(tg));
    endtask

    initial begin
        int unsigned   e1 [16];
        logic [LW-1:0] s, c, e;
        logic [LW-1:0] st_tab [20];
        logic [LW-1:0] ct_tab [20];
        int            k, cyc, g;
        logic          acc;

        e1 = '{2089068860, 1384985267, 1282539355, 2108546761, 1877525866, 552155765,
               1903059489, 968278844, 284689569, 205589740, 1102472041, 711964936,
               711950480, 926161915, 1248126913, 464369286};

        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("rst_valid", LW'(out_valid), LW'(0));
        chk("rst_state", st_out, '0);
        chk("rst_tag", LW'(tag_out), LW'(0));
        chk("rst_err", LW'(err), LW'(0));
        chk("rst_ready", LW'(in_ready), LW'(1));

        for (int i = 0; i < WIDTH; i++) begin
            s[i*31 +: 31] = 31'(i + 1);
            c[i*31 +: 31] = 31'(100 * (i + 1));
            e[i*31 +: 31] = 31'(e1[i]);
        end
        run_dir("full_vec", 1'b0, 8'hA1, s, c, e);

        for (int i = 0; i < WIDTH; i++) begin
            s[i*31 +: 31] = '0;
            c[i*31 +: 31] = 31'd1000;
            e[i*31 +: 31] = 31'd136065185;
        end
        run_dir("full_const", 1'b0, 8'h5C, s, c, e);

        for (int i = 0; i < WIDTH; i++) begin
            c[i*31 +: 31] = (i == 0) ? 31'd1 : 31'd999;
            e[i*31 +: 31] = (i == 0) ? 31'd2147483646 : 31'd1;
        end
        run_dir("partial_vec", 1'b1, 8'h3E, s, c, e);

        // Back-to-back with out_ready toggling every three cycles.
        for (int i = 0; i < 20; i++) begin
            st_tab[i] = rand_vec();
            ct_tab[i] = rand_vec();
        end
        @(posedge clk); #1;
        n_out = 0; k = 0; cyc = 0;
        while (k < 20 && cyc < 400) begin
            out_ready = ((cyc / 3) % 2) == 0;
            in_valid  = 1'b1;
            mode      = k[0];
            tag_in    = 8'(k);
            st_in     = st_tab[k];
            ct_in     = ct_tab[k];
            @(negedge clk);
            acc = in_ready;
            @(posedge clk); #1;
            if (acc) k++;
            cyc++;
        end
        in_valid = 1'b0;
        chk("b2b_accepted", LW'(k), LW'(20));
        g = 0;
        while (q.size() != 0 && g < 200) begin
            out_ready = ((cyc / 3) % 2) == 0;
            @(posedge clk); #1;
            cyc++; g++;
        end
        chk("b2b_count", LW'(n_out), LW'(20));
        out_ready = 1'b1;

        // Random traffic and random backpressure.
        for (int i = 0; i < 200; i++) begin
            in_valid  = $urandom_range(0, 3) != 0;
            mode      = 1'($urandom_range(0, 1));
            tag_in    = 8'($urandom);
            st_in     = rand_vec();
            ct_in     = rand_vec();
            out_ready = $urandom_range(0, 2) != 0;
            @(posedge clk); #1;
        end
        in_valid = 1'b0; out_ready = 1'b1;
        g = 0;
        while (q.size() != 0 && g < 100) begin
            @(posedge clk); #1;
            g++;
        end
        chk("rand_drain", LW'(q.size()), LW'(0));

        // Reset with five transactions in flight.
        for (int i = 0; i < 5; i++) begin
            in_valid = 1'b1; mode = 1'(i); tag_in = 8'(i); st_in = rand_vec(); ct_in = rand_vec();
            @(posedge clk); #1;
        end
        in_valid = 1'b0; rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        for (int i = 0; i < 14; i++) begin
            @(negedge clk);
            chk("rst_flush_valid", LW'(out_valid), LW'(0));
            chk("rst_flush_state", st_out, '0);
        end

        // Reset while the output is stalled.
        @(posedge clk); #1;
        out_ready = 1'b0;
        in_valid = 1'b1; mode = 1'b0; tag_in = 8'h77; st_in = rand_vec(); ct_in = rand_vec();
        @(posedge clk); #1;
        in_valid = 1'b0;
        g = 0;
        while (!out_valid && g < 40) begin
            @(posedge clk); #1;
            g++;
        end
        chk("stall_reached", LW'(out_valid), LW'(1));
        chk("stall_ready", LW'(in_ready), LW'(0));
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        chk("stall_rst_valid", LW'(out_valid), LW'(0));
        chk("stall_rst_state", st_out, '0);
        chk("stall_rst_tag", LW'(tag_out), LW'(0));
        chk("stall_rst_ready", LW'(in_ready), LW'(1));
        out_ready = 1'b1;

        // Non-canonical lane.
        @(posedge clk); #1;
        s = rand_vec();
        s[3*31 +: 31] = 31'h7FFF_FFFF;
        in_valid = 1'b1; mode = 1'b0; tag_in = 8'hE3; st_in = s; ct_in = rand_vec();
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(negedge clk);
`ifdef M31_ROUND_CHECK_EN
        chk("err_set", LW'(err), LW'(1));
        repeat (20) @(negedge clk);
        chk("err_sticky", LW'(err), LW'(1));
`else
        chk("err_tied", LW'(err), LW'(0));
        repeat (20) @(negedge clk);
        chk("err_tied_late", LW'(err), LW'(0));
`endif
        chk("final_drain", LW'(q.size()), LW'(0));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
